// File: rtl/tl_dma_arbiter.sv
// tl_dma_arbiter: round-robin arbiter funnelling NoC TileLink DMA channels onto
// one shared master port. A path is combinational with a grant lock while the
// master stalls; D responses are routed back by the master-side source (which
// carries the channel index) and the channel's original source is restored.
// Optional build macro: DMA_ARB_WATCHDOG_EN adds a per-channel response timeout.
module tl_dma_arbiter #(
  parameter int NoC       = 2,
  parameter int TL_RS     = 4,
  parameter int WD_CYCLES = 1024
) (
  input  logic                   dma_clock_i,
  input  logic                   dma_reset_i,
  input  logic [3*NoC-1:0]       sa_opcode,
  input  logic [3*NoC-1:0]       sa_param,
  input  logic [4*NoC-1:0]       sa_size,
  input  logic [TL_RS*NoC-1:0]   sa_source,
  input  logic [32*NoC-1:0]      sa_address,
  input  logic [32*NoC-1:0]      sa_data,
  input  logic [4*NoC-1:0]       sa_mask,
  input  logic [NoC-1:0]         sa_corrupt,
  input  logic [NoC-1:0]         sa_valid,
  output logic [NoC-1:0]         sa_ready,
  output logic [3*NoC-1:0]       sd_opcode,
  output logic [2*NoC-1:0]       sd_param,
  output logic [4*NoC-1:0]       sd_size,
  output logic [TL_RS*NoC-1:0]   sd_source,
  output logic [32*NoC-1:0]      sd_data,
  output logic [NoC-1:0]         sd_denied,
  output logic [NoC-1:0]         sd_corrupt,
  output logic [NoC-1:0]         sd_valid,
  input  logic [NoC-1:0]         sd_ready,
  output logic [2:0]             m_a_opcode,
  output logic [2:0]             m_a_param,
  output logic [3:0]             m_a_size,
  output logic [TL_RS-1:0]       m_a_source,
  output logic [31:0]            m_a_address,
  output logic [3:0]             m_a_mask,
  output logic [31:0]            m_a_data,
  output logic                   m_a_corrupt,
  output logic                   m_a_valid,
  input  logic                   m_a_ready,
  input  logic [2:0]             m_d_opcode,
  input  logic [1:0]             m_d_param,
  input  logic [3:0]             m_d_size,
  input  logic [TL_RS-1:0]       m_d_source,
  input  logic                   m_d_denied,
  input  logic [31:0]            m_d_data,
  input  logic                   m_d_corrupt,
  input  logic                   m_d_valid,
  output logic                   m_d_ready,
  output logic [NoC-1:0]         arb_err_o
);
  localparam int            CW    = (NoC > 1) ? $clog2(NoC) : 1;
  localparam logic [CW:0]   NOC_W = (CW+1)'(NoC);
  localparam logic [CW-1:0] LAST  = CW'(NoC - 1);

  logic [NoC-1:0]            r_out;
  logic [NoC-1:0][TL_RS-1:0] r_src;
  logic                      r_lock;
  logic [CW-1:0]             r_lock_ch;
  logic [CW-1:0]             r_ptr;
  logic [NoC-1:0]            r_err;

  logic [NoC-1:0] w_elig;
  logic [CW-1:0]  w_win;
  logic [CW:0]    w_idx;
  logic           w_found;
  logic           w_a_hs;
  logic [CW-1:0]  w_ch, w_ch_mod;
  logic           w_ch_in, w_ch_ok, w_stray, w_d_hs;

  assign w_elig = sa_valid & ~r_out;

  // Winner select: locked channel while stalled, otherwise first eligible from r_ptr.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    if (r_lock) begin
      w_win   = r_lock_ch;
      w_found = sa_valid[r_lock_ch];  // requester withdrew: drop the grant this cycle
    end else begin
      for (int k = 0; k < NoC; k++) begin
        w_idx = {1'b0, r_ptr} + (CW+1)'(k);
        if (w_idx >= NOC_W) w_idx = w_idx - NOC_W;
        if (!w_found && w_elig[w_idx[CW-1:0]]) begin
          w_found = 1'b1;
          w_win   = w_idx[CW-1:0];
        end
      end
    end
  end

  assign m_a_valid   = dma_reset_i & w_found;
  assign w_a_hs      = m_a_valid & m_a_ready;
  assign m_a_opcode  = sa_opcode[w_win*3 +: 3];
  assign m_a_param   = sa_param[w_win*3 +: 3];
  assign m_a_size    = sa_size[w_win*4 +: 4];
  assign m_a_address = sa_address[w_win*32 +: 32];
  assign m_a_data    = sa_data[w_win*32 +: 32];
  assign m_a_mask    = sa_mask[w_win*4 +: 4];
  assign m_a_corrupt = sa_corrupt[w_win];

  // Master source carries the channel index; ready goes back to the winner only.
  always_comb begin
    m_a_source         = '0;
    m_a_source[CW-1:0] = w_win;
    sa_ready           = '0;
    if (m_a_valid) sa_ready[w_win] = m_a_ready;
  end

  // D routing: the channel index sits in the low source bits; out-of-range
  // indices fold back so error reporting always lands on a real channel.
  assign w_ch     = (NoC > 1) ? m_d_source[CW-1:0] : '0;
  assign w_ch_in  = ({1'b0, w_ch} < NOC_W);
  assign w_ch_mod = w_ch_in ? w_ch : (w_ch - NOC_W[CW-1:0]);
  assign w_ch_ok  = w_ch_in & r_out[w_ch_mod];
  assign w_stray  = dma_reset_i & m_d_valid & ~w_ch_ok;
  assign w_d_hs   = dma_reset_i & m_d_valid & w_ch_ok & sd_ready[w_ch_mod];
  // During reset responses are drained unconditionally.
  assign m_d_ready = ~dma_reset_i | w_stray | (w_ch_ok & sd_ready[w_ch_mod]);

  assign sd_opcode  = {NoC{m_d_opcode}};
  assign sd_param   = {NoC{m_d_param}};
  assign sd_size    = {NoC{m_d_size}};
  assign sd_data    = {NoC{m_d_data}};
  assign sd_denied  = {NoC{m_d_denied}};
  assign sd_corrupt = {NoC{m_d_corrupt}};
  assign sd_source  = r_src;
  assign arb_err_o  = r_err;

  // sd_valid only mirrors a live master beat towards an outstanding channel.
  always_comb begin
    sd_valid = '0;
    if (dma_reset_i && m_d_valid && w_ch_ok) sd_valid[w_ch_mod] = 1'b1;
  end

`ifdef DMA_ARB_WATCHDOG_EN
  localparam int             WDW     = $clog2(WD_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_CYCLES - 1);
  logic [NoC-1:0][WDW-1:0]   r_wd;
`endif

  // Outstanding tracking, source save, lock/pointer update and error pulses.
  always_ff @(posedge dma_clock_i) begin
    if (!dma_reset_i) begin
      r_out     <= '0;
      r_src     <= '0;
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
      r_ptr     <= '0;
      r_err     <= '0;
`ifdef DMA_ARB_WATCHDOG_EN
      r_wd      <= '0;
`endif
    end else begin
      r_err <= '0;
      if (w_stray) r_err[w_ch_mod] <= 1'b1;
      if (w_d_hs)  r_out[w_ch_mod] <= 1'b0;
      if (w_a_hs) begin
        r_out[w_win] <= 1'b1;
        r_src[w_win] <= sa_source[w_win*TL_RS +: TL_RS];
        r_lock       <= 1'b0;
        r_ptr        <= (w_win == LAST) ? '0 : w_win + 1'b1;
      end else if (m_a_valid) begin
        r_lock    <= 1'b1;
        r_lock_ch <= w_win;
      end else begin
        r_lock <= 1'b0;
      end
`ifdef DMA_ARB_WATCHDOG_EN
      // A response arriving on the final cycle wins over the timeout.
      for (int i = 0; i < NoC; i++) begin
        if (r_out[i] && !(w_d_hs && w_ch_mod == CW'(i))) begin
          if (r_wd[i] == WD_LAST) begin
            r_out[i] <= 1'b0;
            r_err[i] <= 1'b1;
            r_wd[i]  <= '0;
          end else begin
            r_wd[i] <= r_wd[i] + 1'b1;
          end
        end else begin
          r_wd[i] <= '0;
        end
      end
`endif
    end
  end
endmodule
